// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - command responder: register-memory read/write, divider config, multi-cycle ALU
// Accepted commands execute immediately except ALU ops, which hold Busy for DivCfg+1 cycles.
module cmd_responder #(
  parameter int INBITS = 8,
  parameter int WIDTH  = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ValidCmd,
  input  logic                  RW,
  input  logic                  ConfigDiv,
  input  logic                  InputKey,
  input  logic [3:0]            Sel,
  input  logic [31:0]           Din,
  input  logic [WIDTH-1:0]      Addr,
  input  logic [INBITS-1:0]     inA,
  input  logic [INBITS-1:0]     inB,
  output logic [31:0]           Dout,
  output logic                  DoutValid,
  output logic [2*INBITS-1:0]   AluOut,
  output logic                  AluValid,
  output logic                  Busy,
  output logic                  CmdErr,
  output logic [3:0]            DivCfg
);

  localparam int W2 = 2 * INBITS;
  localparam logic [W2-1:0] C_W2 = W2[W2-1:0];

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          r_sel;
  logic [INBITS-1:0]   r_a;
  logic [INBITS-1:0]   r_b;
  logic [31:0]         r_mem [0:(2**WIDTH)-1];
  logic [31:0]         r_dout;
  logic                r_dout_valid;
  logic [W2-1:0]       r_alu_out;
  logic                r_alu_valid;
  logic                r_cmd_err;
  logic [3:0]          r_div;

  logic                w_busy;
  logic                w_done;
  logic                w_accept;
  logic                w_sel_legal;
  logic                w_alu_start;
  logic                w_wr;
  logic                w_rd;
  logic                w_cfg;
  logic                w_err;
  logic [W2-1:0]       w_a;
  logic [W2-1:0]       w_b;
  logic [W2-1:0]       w_sh;
  logic [W2-1:0]       w_result;

  assign w_sel_legal = (Sel != 4'd0) && (Sel <= 4'd9);
  assign w_accept    = ValidCmd && InputKey && !w_busy;
  assign w_cfg       = w_accept && ConfigDiv;
  assign w_alu_start = w_accept && !ConfigDiv && w_sel_legal;
  assign w_wr        = w_accept && !ConfigDiv && (Sel == 4'd0) && RW;
  assign w_rd        = w_accept && !ConfigDiv && (Sel == 4'd0) && !RW;
  // Illegal opcodes are treated as rejected, never as accepted.
  assign w_err       = (ValidCmd && (!InputKey || w_busy))
                    || (w_accept && !ConfigDiv && (Sel != 4'd0) && !w_sel_legal);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_alu_start) w_state_nxt = S_EXEC;
      S_EXEC: if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_EXEC);
    w_done = (r_state == S_EXEC) && (r_cnt == 4'd0);
  end

  assign w_a  = {{INBITS{1'b0}}, r_a};
  assign w_b  = {{INBITS{1'b0}}, r_b};
  assign w_sh = w_b % C_W2;

  always_comb begin
    w_result = '0;
    case (r_sel)
      4'd1: w_result = w_a + w_b;
      4'd2: w_result = w_a - w_b;
      4'd3: w_result = w_a * w_b;
      4'd4: w_result = w_a & w_b;
      4'd5: w_result = w_a | w_b;
      4'd6: w_result = w_a ^ w_b;
      4'd7: w_result = w_a << w_sh;
      4'd8: w_result = w_a >> w_sh;
      4'd9: w_result = {{(W2-1){1'b0}}, (r_a > r_b)};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= 4'd0;
      r_sel <= 4'd0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_alu_start) begin
      r_cnt <= r_div;
      r_sel <= Sel;
      r_a   <= inA;
      r_b   <= inB;
    end else if (w_busy && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive Reset.
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[Addr] <= Din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dout       <= 32'd0;
      r_dout_valid <= 1'b0;
      r_alu_out    <= '0;
      r_alu_valid  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_div        <= 4'd0;
    end else begin
      r_dout_valid <= w_rd;
      r_alu_valid  <= w_done;
      r_cmd_err    <= w_err;
      if (w_rd)   r_dout    <= r_mem[Addr];
      if (w_done) r_alu_out <= w_result;
      if (w_cfg)  r_div     <= Din[3:0];
    end
  end

  assign Dout      = r_dout;
  assign DoutValid = r_dout_valid;
  assign AluOut    = r_alu_out;
  assign AluValid  = r_alu_valid;
  assign Busy      = w_busy;
  assign CmdErr    = r_cmd_err;
  assign DivCfg    = r_div;

endmodule

// File: tb/tb_cmd_responder.sv
// tb/tb_cmd_responder.sv - self-checking bench for cmd_responder
// Result values go through scoreboard queues; cycle timing is checked inline.
module tb_cmd_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ValidCmd = 1'b0;
  logic        RW = 1'b0;
  logic        ConfigDiv = 1'b0;
  logic        InputKey = 1'b0;
  logic [3:0]  Sel = 4'd0;
  logic [31:0] Din = 32'd0;
  logic [7:0]  Addr = 8'd0;
  logic [7:0]  inA = 8'd0;
  logic [7:0]  inB = 8'd0;
  logic [31:0] Dout;
  logic        DoutValid;
  logic [15:0] AluOut;
  logic        AluValid;
  logic        Busy;
  logic        CmdErr;
  logic [3:0]  DivCfg;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  logic [31:0] q_dout[$];
  logic [15:0] q_alu[$];

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[14];

  cmd_responder #(.INBITS(8), .WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .ValidCmd(ValidCmd), .RW(RW), .ConfigDiv(ConfigDiv),
    .InputKey(InputKey), .Sel(Sel), .Din(Din), .Addr(Addr), .inA(inA), .inB(inB),
    .Dout(Dout), .DoutValid(DoutValid), .AluOut(AluOut), .AluValid(AluValid),
    .Busy(Busy), .CmdErr(CmdErr), .DivCfg(DivCfg)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (DoutValid === 1'b1) begin
      check("DoutValid pulse expected", {31'd0, DoutValid}, {31'd0, q_dout.size() != 0});
      if (q_dout.size() != 0) check("Dout value", Dout, q_dout.pop_front());
    end
    if (AluValid === 1'b1) begin
      check("AluValid pulse expected", {31'd0, AluValid}, {31'd0, q_alu.size() != 0});
      if (q_alu.size() != 0) check("AluOut value", {16'd0, AluOut}, {16'd0, q_alu.pop_front()});
    end
    if (CmdErr === 1'b1) begin
      check("CmdErr pulse expected", {31'd0, CmdErr}, {31'd0, exp_err > 0});
      if (exp_err > 0) exp_err--;
    end
  end

  // Called right after a falling edge; returns at the falling edge after the command edge.
  task automatic cmd(input logic key, input logic rw, input logic cfg, input logic [3:0] sel,
                     input logic [31:0] din, input logic [7:0] addr, input logic [7:0] a,
                     input logic [7:0] b);
    ValidCmd = 1'b1; InputKey = key; RW = rw; ConfigDiv = cfg; Sel = sel;
    Din = din; Addr = addr; inA = a; inB = b;
    @(posedge Clk);
    @(negedge Clk);
    ValidCmd = 1'b0; InputKey = 1'b0; RW = 1'b0; ConfigDiv = 1'b0; Sel = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Dout"}, Dout, 32'd0);
    check({tag, " DoutValid"}, {31'd0, DoutValid}, 32'd0);
    check({tag, " AluOut"}, {16'd0, AluOut}, 32'd0);
    check({tag, " AluValid"}, {31'd0, AluValid}, 32'd0);
    check({tag, " Busy"}, {31'd0, Busy}, 32'd0);
    check({tag, " CmdErr"}, {31'd0, CmdErr}, 32'd0);
    check({tag, " DivCfg"}, {28'd0, DivCfg}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd1, 8'd200, 8'd100, 16'd300};
    vecs[1]  = '{4'd1, 8'd255, 8'd255, 16'h01FE};
    vecs[2]  = '{4'd2, 8'd1,   8'd2,   16'hFFFF};
    vecs[3]  = '{4'd3, 8'd255, 8'd255, 16'hFE01};
    vecs[4]  = '{4'd4, 8'hF0,  8'h3C,  16'h0030};
    vecs[5]  = '{4'd5, 8'hF0,  8'h0F,  16'h00FF};
    vecs[6]  = '{4'd6, 8'hFF,  8'h0F,  16'h00F0};
    vecs[7]  = '{4'd7, 8'h01,  8'd17,  16'h0002};
    vecs[8]  = '{4'd7, 8'hFF,  8'd8,   16'hFF00};
    vecs[9]  = '{4'd8, 8'h80,  8'd3,   16'h0010};
    vecs[10] = '{4'd8, 8'hF0,  8'd20,  16'h000F};
    vecs[11] = '{4'd9, 8'd5,   8'd3,   16'h0001};
    vecs[12] = '{4'd9, 8'd3,   8'd5,   16'h0000};
    vecs[13] = '{4'd9, 8'd7,   8'd7,   16'h0000};

    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;
    @(negedge Clk);

    // Basic write then read-back, plus a few more addresses.
    cmd(1, 1, 0, 0, 32'hDEADBEEF, 8'h10, 0, 0);
    q_dout.push_back(32'hDEADBEEF);
    cmd(1, 0, 0, 0, 0, 8'h10, 0, 0);
    check("read pulse timing", {31'd0, DoutValid}, 32'd1);
    @(negedge Clk);
    check("read single pulse", {31'd0, DoutValid}, 32'd0);
    check("Dout held", Dout, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      cmd(1, 1, 0, 0, d, 8'(8'hF0 + i), 0, 0);
      q_dout.push_back(d);
      cmd(1, 0, 0, 0, 0, 8'(8'hF0 + i), 0, 0);
    end

    // Zero-latency ALU table.
    for (int i = 0; i < 14; i++) begin
      q_alu.push_back(vecs[i].exp);
      cmd(1, 0, 0, vecs[i].sel, 0, 0, vecs[i].a, vecs[i].b);
      check("alu busy during exec", {31'd0, Busy}, 32'd1);
      check("alu no early valid", {31'd0, AluValid}, 32'd0);
      @(negedge Clk);
      check("alu valid after 1", {31'd0, AluValid}, 32'd1);
      check("alu busy dropped", {31'd0, Busy}, 32'd0);
    end

    // Divider latency 3 with a Busy rejection two cycles after accept.
    cmd(1, 0, 1, 0, 32'd3, 0, 0, 0);
    check("DivCfg set", {28'd0, DivCfg}, 32'd3);
    q_alu.push_back(16'hFE01);
    cmd(1, 0, 0, 4'd3, 0, 0, 8'd255, 8'd255);
    @(negedge Clk);
    exp_err++;
    cmd(1, 0, 0, 4'd1, 0, 0, 8'd1, 8'd1);
    check("busy reject CmdErr", {31'd0, CmdErr}, 32'd1);
    check("busy at E2", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    check("no valid at E3", {31'd0, AluValid}, 32'd0);
    check("busy at E3", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    check("valid at E4", {31'd0, AluValid}, 32'd1);
    check("div AluOut", {16'd0, AluOut}, 32'h0000FE01);
    check("busy low at E4", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    check("AluOut held", {16'd0, AluOut}, 32'h0000FE01);

    // Key rejection leaves memory untouched; illegal opcode leaves ALU idle.
    cmd(1, 1, 0, 0, 32'h11111111, 8'h20, 0, 0);
    exp_err++;
    cmd(0, 1, 0, 0, 32'h22222222, 8'h20, 0, 0);
    check("key reject CmdErr", {31'd0, CmdErr}, 32'd1);
    q_dout.push_back(32'h11111111);
    cmd(1, 0, 0, 0, 0, 8'h20, 0, 0);
    exp_err++;
    cmd(1, 0, 0, 4'd12, 0, 0, 8'd9, 8'd9);
    check("illegal op CmdErr", {31'd0, CmdErr}, 32'd1);
    check("illegal op no busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    check("illegal op AluValid", {31'd0, AluValid}, 32'd0);
    check("illegal op AluOut", {16'd0, AluOut}, 32'h0000FE01);

    // Reset mid-EXEC.
    cmd(1, 0, 1, 0, 32'd5, 0, 0, 0);
    cmd(1, 0, 0, 4'd3, 0, 0, 8'd10, 8'd10);
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("midreset");
    Reset = 1'b0;
    @(negedge Clk);
    q_alu.push_back(16'd5);
    cmd(1, 0, 0, 4'd1, 0, 0, 8'd2, 8'd3);
    check("post reset busy", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    check("post reset 1-cycle valid", {31'd0, AluValid}, 32'd1);

    repeat (6) @(negedge Clk);
    check("dout queue drained", q_dout.size(), 32'd0);
    check("alu queue drained", q_alu.size(), 32'd0);
    check("CmdErr all seen", exp_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
